// File: rtl/btn_reader_if.sv
// Button reader bus: raw button inputs in, debounced level and event pulses out.
// The reader drives through the slave modport; the master side supplies raw buttons.
interface btn_reader_if #(
  parameter int N_BTN = 4
);
  logic [N_BTN-1:0] btn_i;
  logic [N_BTN-1:0] level_o;
  logic [N_BTN-1:0] press_o;
  logic [N_BTN-1:0] release_o;
  logic [N_BTN-1:0] long_o;

  modport master (
    output btn_i,
    input  level_o, press_o, release_o, long_o
  );

  modport slave (
    input  btn_i,
    output level_o, press_o, release_o, long_o
  );
endinterface

// File: rtl/btn_reader.sv
// Pushbutton reader: 2-flop synchroniser, shared millisecond tick prescaler and a
// per-button debounce FSM producing a clean level plus press/release/long pulses.
// Optional macro BTN_REPEAT_EN adds auto-repeat press pulses while a button is held.
//
// state        | meaning
// IDLE         | released, waiting for a press
// PRESS_WAIT   | input high, counting stable ticks before accepting the press
// PRESSED      | accepted press, counting ticks towards the long-press pulse
// HELD         | long press reported (or release bounce recovered), waiting for release
// RELEASE_WAIT | input low, counting stable ticks before accepting the release
module btn_reader #(
  parameter int N_BTN       = 4,
  parameter int TICK_DIV    = 50000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000,
  parameter int REPEAT_MS   = 200
) (
  input  logic         clk_50_i,
  input  logic         rst_i,
  btn_reader_if.slave  btn
);

  localparam int PW    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int MAX_A = (LONG_MS > DEBOUNCE_MS) ? LONG_MS : DEBOUNCE_MS;
  localparam int MAX_T = (MAX_A > REPEAT_MS) ? MAX_A : REPEAT_MS;
  localparam int TW    = $clog2(MAX_T + 1);

  typedef enum logic [2:0] {
    IDLE         = 3'd0,
    PRESS_WAIT   = 3'd1,
    PRESSED      = 3'd2,
    HELD         = 3'd3,
    RELEASE_WAIT = 3'd4
  } state_t;

  logic [N_BTN-1:0] sync_a;
  logic [N_BTN-1:0] sync_b;
  logic [PW-1:0]    pre_cnt;
  logic             tick;

  logic [N_BTN-1:0] level_v;
  logic [N_BTN-1:0] press_v;
  logic [N_BTN-1:0] release_v;
  logic [N_BTN-1:0] long_v;

  // Two-flop synchroniser; reset value means "released"
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      sync_a <= '0;
      sync_b <= '0;
    end else begin
      sync_a <= btn.btn_i;
      sync_b <= sync_a;
    end
  end

  // Free-running shared prescaler, wraps at TICK_DIV-1
  always_ff @(posedge clk_50_i or posedge rst_i) begin
    if (rst_i) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PW'(TICK_DIV - 1)) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  assign tick = (pre_cnt == PW'(TICK_DIV - 1));

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    state_t        state, state_n;
    logic [TW-1:0] tcnt, tcnt_n;
    logic          sb;
    logic          level_r, press_r, release_r, long_r;
    logic          press_n, release_n, long_n, level_n;

    assign sb = sync_b[g];

    // State, tick counter and registered outputs
    always_ff @(posedge clk_50_i or posedge rst_i) begin
      if (rst_i) begin
        state     <= IDLE;
        tcnt      <= '0;
        level_r   <= 1'b0;
        press_r   <= 1'b0;
        release_r <= 1'b0;
        long_r    <= 1'b0;
      end else begin
        state     <= state_n;
        tcnt      <= tcnt_n;
        level_r   <= level_n;
        press_r   <= press_n;
        release_r <= release_n;
        long_r    <= long_n;
      end
    end

    // Next-state, tick counting and pulse decode
    always_comb begin
      state_n   = state;
      tcnt_n    = tcnt;
      press_n   = 1'b0;
      release_n = 1'b0;
      long_n    = 1'b0;
      case (state)
        IDLE: begin
          if (sb) state_n = PRESS_WAIT;
        end
        PRESS_WAIT: begin
          if (!sb) begin
            state_n = IDLE;
          end else if (tick) begin
            if (tcnt == TW'(DEBOUNCE_MS - 1)) begin
              state_n = PRESSED;
              press_n = 1'b1;
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
        end
        PRESSED: begin
          if (!sb) begin
            state_n = RELEASE_WAIT;
          end else if (tick) begin
            if (tcnt == TW'(LONG_MS - 1)) begin
              state_n = HELD;
              long_n  = 1'b1;
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
        end
        HELD: begin
          if (!sb) begin
            state_n = RELEASE_WAIT;
          end
`ifdef BTN_REPEAT_EN
          else if (tick) begin
            if (tcnt == TW'(REPEAT_MS - 1)) begin
              press_n = 1'b1;
              tcnt_n  = '0;
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
`endif
        end
        RELEASE_WAIT: begin
          // Bounce back high resumes HELD so long/press are never re-reported
          if (sb) begin
            state_n = HELD;
          end else if (tick) begin
            if (tcnt == TW'(DEBOUNCE_MS - 1)) begin
              state_n   = IDLE;
              release_n = 1'b1;
            end else begin
              tcnt_n = tcnt + TW'(1);
            end
          end
        end
        default: state_n = IDLE;
      endcase
      if (state_n != state) tcnt_n = '0;
      level_n = (state_n == PRESSED) || (state_n == HELD) || (state_n == RELEASE_WAIT);
    end

    assign level_v[g]   = level_r;
    assign press_v[g]   = press_r;
    assign release_v[g] = release_r;
    assign long_v[g]    = long_r;
  end

  assign btn.level_o   = level_v;
  assign btn.press_o   = press_v;
  assign btn.release_o = release_v;
  assign btn.long_o    = long_v;

endmodule

// File: tb/tb_btn_reader.sv
// Directed bench for btn_reader with a short tick (TICK_DIV=10, DEBOUNCE_MS=4,
// LONG_MS=20, REPEAT_MS=8). Event cycles are logged by a negedge monitor and
// compared in per-scenario tasks against hand-computed windows.
module tb_btn_reader;

  localparam int NB = 4;

  logic clk_50;
  logic rst;
  int   cyc;
  int   pass_cnt;
  int   total_cnt;

  btn_reader_if #(.N_BTN(NB)) bus_if ();

  btn_reader #(
    .N_BTN(NB), .TICK_DIV(10), .DEBOUNCE_MS(4), .LONG_MS(20), .REPEAT_MS(8)
  ) dut (
    .clk_50_i (clk_50),
    .rst_i    (rst),
    .btn      (bus_if)
  );

  initial clk_50 = 1'b0;
  always #5 clk_50 = ~clk_50;

  initial cyc = 0;
  always @(posedge clk_50) cyc = cyc + 1;

  int       press_cnt [NB];
  int       rel_cnt   [NB];
  int       long_cnt  [NB];
  int       press_first [NB];
  int       press_last  [NB];
  int       rel_cyc   [NB];
  int       long_cyc  [NB];
  int       overlap;
  logic [NB-1:0] lvl_seen;

  // Event monitor sampling on the falling edge
  always @(negedge clk_50) begin
    if (!rst) begin
      for (int i = 0; i < NB; i++) begin
        if (bus_if.press_o[i]) begin
          if (press_cnt[i] == 0) press_first[i] = cyc;
          press_last[i] = cyc;
          press_cnt[i]++;
        end
        if (bus_if.release_o[i]) begin
          rel_cyc[i] = cyc;
          rel_cnt[i]++;
        end
        if (bus_if.long_o[i]) begin
          long_cyc[i] = cyc;
          long_cnt[i]++;
        end
      end
      if (((bus_if.press_o & bus_if.release_o) | (bus_if.press_o & bus_if.long_o) |
           (bus_if.release_o & bus_if.long_o)) != '0)
        overlap++;
      lvl_seen = lvl_seen | bus_if.level_o;
    end
  end

  task automatic clr_mon();
    for (int i = 0; i < NB; i++) begin
      press_cnt[i] = 0; rel_cnt[i] = 0; long_cnt[i] = 0;
      press_first[i] = 0; press_last[i] = 0; rel_cyc[i] = 0; long_cyc[i] = 0;
    end
    overlap  = 0;
    lvl_seen = '0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_50);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_if.btn_i = '0;
    step(5);
    total_cnt++;
    if ({bus_if.level_o, bus_if.press_o, bus_if.release_o, bus_if.long_o} !== 16'h0)
      $display("FAIL reset_outputs: got %h want 0000",
               {bus_if.level_o, bus_if.press_o, bus_if.release_o, bus_if.long_o});
    else pass_cnt++;
    rst = 1'b0;
    clr_mon();
    step(500);
    total_cnt++;
    if (lvl_seen !== 4'h0) $display("FAIL idle_level: got %h want 0", lvl_seen);
    else pass_cnt++;
    total_cnt++;
    if (press_cnt[0] + press_cnt[1] + press_cnt[2] + press_cnt[3] +
        rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] +
        long_cnt[0] + long_cnt[1] + long_cnt[2] + long_cnt[3] != 0)
      $display("FAIL idle_pulses: got nonzero pulse count want 0");
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    clr_mon();
    bus_if.btn_i[0] = 1'b1;
    step(25);
    bus_if.btn_i[0] = 1'b0;
    step(100);
    total_cnt++;
    if (press_cnt[0] != 0) $display("FAIL glitch_press: got %0d want 0", press_cnt[0]);
    else pass_cnt++;
    total_cnt++;
    if (lvl_seen[0] !== 1'b0) $display("FAIL glitch_level: got %b want 0", lvl_seen[0]);
    else pass_cnt++;
  endtask

  task automatic test_clean_press();
    int c0;
    int c1;
    clr_mon();
    c0 = cyc;
    bus_if.btn_i[1] = 1'b1;
    step(100);
    total_cnt++;
    if (press_cnt[1] != 1) $display("FAIL clean_press_cnt: got %0d want 1", press_cnt[1]);
    else pass_cnt++;
    total_cnt++;
    if (press_first[1] - c0 < 33 || press_first[1] - c0 > 43)
      $display("FAIL clean_press_latency: got %0d want 33..43", press_first[1] - c0);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.level_o[1] !== 1'b1) $display("FAIL clean_level_hi: got %b want 1", bus_if.level_o[1]);
    else pass_cnt++;
    c1 = cyc;
    bus_if.btn_i[1] = 1'b0;
    step(60);
    total_cnt++;
    if (rel_cnt[1] != 1) $display("FAIL clean_release_cnt: got %0d want 1", rel_cnt[1]);
    else pass_cnt++;
    total_cnt++;
    if (rel_cyc[1] - c1 < 33 || rel_cyc[1] - c1 > 43)
      $display("FAIL clean_release_latency: got %0d want 33..43", rel_cyc[1] - c1);
    else pass_cnt++;
    total_cnt++;
    if (long_cnt[1] != 0) $display("FAIL clean_no_long: got %0d want 0", long_cnt[1]);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.level_o[1] !== 1'b0) $display("FAIL clean_level_lo: got %b want 0", bus_if.level_o[1]);
    else pass_cnt++;
  endtask

  task automatic test_long_press();
    clr_mon();
    bus_if.btn_i[2] = 1'b1;
    step(400);
    total_cnt++;
    if (long_cnt[2] != 1) $display("FAIL long_cnt: got %0d want 1", long_cnt[2]);
    else pass_cnt++;
    total_cnt++;
    if (long_cyc[2] - press_first[2] != 200)
      $display("FAIL long_gap: got %0d want 200", long_cyc[2] - press_first[2]);
    else pass_cnt++;
    for (int k = 0; k < 2; k++) begin
      bus_if.btn_i[2] = 1'b0;
      step(15);
      bus_if.btn_i[2] = 1'b1;
      step(15);
    end
    bus_if.btn_i[2] = 1'b0;
    step(80);
    total_cnt++;
    if (rel_cnt[2] != 1) $display("FAIL bounce_release_cnt: got %0d want 1", rel_cnt[2]);
    else pass_cnt++;
    total_cnt++;
    if (press_cnt[2] != 1 || long_cnt[2] != 1)
      $display("FAIL bounce_no_repress: got press %0d long %0d want 1 1", press_cnt[2], long_cnt[2]);
    else pass_cnt++;
    total_cnt++;
    if (overlap != 0) $display("FAIL pulse_overlap: got %0d want 0", overlap);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    clr_mon();
    bus_if.btn_i = 4'hF;
    step(100);
    total_cnt++;
    if (press_cnt[0] != 1 || press_cnt[1] != 1 || press_cnt[2] != 1 || press_cnt[3] != 1)
      $display("FAIL simul_press_cnt: got %0d %0d %0d %0d want 1 1 1 1",
               press_cnt[0], press_cnt[1], press_cnt[2], press_cnt[3]);
    else pass_cnt++;
    total_cnt++;
    if (press_first[1] != press_first[0] || press_first[2] != press_first[0] ||
        press_first[3] != press_first[0])
      $display("FAIL simul_same_cycle: got %0d %0d %0d %0d want all equal",
               press_first[0], press_first[1], press_first[2], press_first[3]);
    else pass_cnt++;
    total_cnt++;
    if (bus_if.level_o !== 4'hF) $display("FAIL simul_level: got %h want f", bus_if.level_o);
    else pass_cnt++;
    #3;
    rst = 1'b1;
    #1;
    total_cnt++;
    if (bus_if.level_o !== 4'h0) $display("FAIL async_reset_level: got %h want 0", bus_if.level_o);
    else pass_cnt++;
    bus_if.btn_i = 4'h0;
    step(5);
    rst = 1'b0;
    clr_mon();
    step(100);
    total_cnt++;
    if (rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3] != 0)
      $display("FAIL reset_no_release: got %0d want 0",
               rel_cnt[0] + rel_cnt[1] + rel_cnt[2] + rel_cnt[3]);
    else pass_cnt++;
    total_cnt++;
    if (lvl_seen !== 4'h0) $display("FAIL reset_level_after: got %h want 0", lvl_seen);
    else pass_cnt++;
  endtask

  task automatic test_repeat();
`ifdef BTN_REPEAT_EN
    int exp_press = 4;
`else
    int exp_press = 1;
`endif
    clr_mon();
    bus_if.btn_i[0] = 1'b1;
    step(500);
    total_cnt++;
    if (press_cnt[0] != exp_press)
      $display("FAIL repeat_press_cnt: got %0d want %0d", press_cnt[0], exp_press);
    else pass_cnt++;
    total_cnt++;
    if (long_cnt[0] != 1) $display("FAIL repeat_long_cnt: got %0d want 1", long_cnt[0]);
    else pass_cnt++;
`ifdef BTN_REPEAT_EN
    total_cnt++;
    if (press_last[0] - long_cyc[0] != 240)
      $display("FAIL repeat_period: got %0d want 240", press_last[0] - long_cyc[0]);
    else pass_cnt++;
`endif
    bus_if.btn_i[0] = 1'b0;
    step(60);
    total_cnt++;
    if (rel_cnt[0] != 1) $display("FAIL repeat_release_cnt: got %0d want 1", rel_cnt[0]);
    else pass_cnt++;
  endtask

  initial begin
    pass_cnt  = 0;
    total_cnt = 0;
    rst = 1'b1;
    bus_if.btn_i = '0;
    clr_mon();
    test_reset();
    test_glitch();
    test_clean_press();
    test_long_press();
    test_simultaneous();
    test_repeat();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
